gray_cnt_rx: RTL and testbench

GRAY_CNT_RX -- requirements
Module: gray_cnt_rx

---
 rtl/gray_cnt_rx.sv | 143 ++++++++++++++
 tb/tb_gray_cnt_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_cnt_rx.sv
// Receives a gray-coded count from a foreign clock domain and turns its advance into
// a backlog of increments that downstream logic consumes one at a time over a valid/ready handshake.
module gray_cnt_rx #(
  parameter int unsigned W           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  gray_in,
  output logic [W-1:0]  cnt,
  output logic [W-1:0]  delta,
  output logic          inc_valid,
  input  logic          inc_ready,
  output logic [BW-1:0] backlog,
  output logic          err,
  output logic          ovf
);

  localparam int unsigned IW = $clog2(SYNC_STAGES + 1);
  localparam int unsigned SW = BW + W + 1;
  localparam logic [SW-1:0] BL_MAX = SW'({BW{1'b1}});

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [IW-1:0]                   init_cnt_q, init_cnt_d;
  logic [SYNC_STAGES-1:0][W-1:0]   sync_q, sync_d;
  logic [W-1:0]                    prev_gray_q, prev_gray_d;
  logic [W-1:0]                    cnt_q, cnt_d;
  logic [W-1:0]                    delta_q, delta_d;
  logic [BW-1:0]                   backlog_q, backlog_d;
  logic                            inc_valid_q, inc_valid_d;
  logic                            err_q, err_d;
  logic                            ovf_q, ovf_d;

  logic [W-1:0]                    gray_s;
  logic [W-1:0]                    bin_c;
  logic                            multi_flip_c;
  logic                            xfer_c;
  logic [SW-1:0]                   bl_sum_c;

  // Only the last synchronizer stage is allowed to feed logic
  assign sync_d = {sync_q[SYNC_STAGES-2:0], gray_in};
  assign gray_s = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      bin_c[i] = ^(gray_s >> i);
    end
  end

  assign multi_flip_c = $countones(gray_s ^ prev_gray_q) > 1;

  // Synchronizer fill, start-value capture, then continuous decoding
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    prev_gray_d = prev_gray_q;
    cnt_d       = cnt_q;
    delta_d     = '0;
    err_d       = err_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == IW'(SYNC_STAGES - 1)) begin
          state_d = ST_PRIME;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      ST_PRIME: begin
        cnt_d       = bin_c;
        prev_gray_d = gray_s;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        cnt_d       = bin_c;
        delta_d     = bin_c - cnt_q;
        prev_gray_d = gray_s;
        if (multi_flip_c) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Backlog absorbs the last delta and retires one accepted increment in the same cycle
  assign xfer_c   = inc_valid_q & inc_ready;
  assign bl_sum_c = SW'(backlog_q) + SW'(delta_q) - SW'(xfer_c);

  always_comb begin
    backlog_d = bl_sum_c[BW-1:0];
    ovf_d     = ovf_q;
    if (bl_sum_c > BL_MAX) begin
      backlog_d = '1;
      ovf_d     = 1'b1;
    end
    inc_valid_d = (backlog_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      sync_q      <= '0;
      prev_gray_q <= '0;
      cnt_q       <= '0;
      delta_q     <= '0;
      backlog_q   <= '0;
      inc_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      sync_q      <= sync_d;
      prev_gray_q <= prev_gray_d;
      cnt_q       <= cnt_d;
      delta_q     <= delta_d;
      backlog_q   <= backlog_d;
      inc_valid_q <= inc_valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cnt       = cnt_q;
  assign delta     = delta_q;
  assign backlog   = backlog_q;
  assign inc_valid = inc_valid_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gray_cnt_rx.sv
// Bench for gray_cnt_rx: table-driven step vectors, hand-written corner sequences and a
// randomized gray walk compared against a history-based reference model.
module tb_gray_cnt_rx;

  localparam int SS  = 2;
  localparam int BWA = 8;
  localparam int BWB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gray_in;
  logic       inc_ready, inc_ready4;
  logic [7:0] cnt, delta, cnt4, delta4;
  logic       inc_valid, inc_valid4, err, err4, ovf, ovf4;
  logic [BWA-1:0] backlog;
  logic [BWB-1:0] backlog4;

  gray_cnt_rx #(.W(8), .SYNC_STAGES(SS), .BW(BWA)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .cnt(cnt), .delta(delta),
    .inc_valid(inc_valid), .inc_ready(inc_ready), .backlog(backlog), .err(err), .ovf(ovf)
  );

  gray_cnt_rx #(.W(8), .SYNC_STAGES(SS), .BW(BWB)) dut4 (
    .clk(clk), .rst(rst), .gray_in(gray_in), .cnt(cnt4), .delta(delta4),
    .inc_valid(inc_valid4), .inc_ready(inc_ready4), .backlog(backlog4), .err(err4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: history of every sampled gray value plus abstract counters
  logic [7:0] hist[$];
  int n;
  int m_cnt, m_delta, m_bl, m_bl4;
  bit m_err, m_ovf, m_ovf4;
  int xfer_obs, xfer_obs4;

  typedef struct {
    logic [7:0] g;
    bit         rdy;
    int         cnt;
    int         dsum;
    int         bl;
    bit         er;
    int         xf;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int gdec(input int g);
    for (int b = 0; b < 256; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic logic [7:0] genc(input int b);
    logic [7:0] v;
    v = 8'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int pop(input int x);
    int c = 0;
    for (int i = 0; i < 8; i++) c += x[i];
    return c;
  endfunction

  task automatic model_clear();
    hist.delete();
    n = 0; m_cnt = 0; m_delta = 0; m_bl = 0; m_bl4 = 0;
    m_err = 0; m_ovf = 0; m_ovf4 = 0;
  endtask

  // Advance model by one edge using the pre-edge inputs, then clock and compare
  task automatic tick();
    int mx, mx4, s, newc, cur, prv;
    n++;
    hist.push_back(gray_in);
    mx  = (m_bl  != 0 && inc_ready)  ? 1 : 0;
    mx4 = (m_bl4 != 0 && inc_ready4) ? 1 : 0;
    s = m_bl + m_delta - mx;
    if (s > 255) begin s = 255; m_ovf = 1; end
    m_bl = s;
    s = m_bl4 + m_delta - mx4;
    if (s > 15) begin s = 15; m_ovf4 = 1; end
    m_bl4 = s;
    if (n <= SS) begin
      m_delta = 0;
    end else if (n == SS + 1) begin
      m_cnt   = gdec(int'(hist[n-SS-1]));
      m_delta = 0;
    end else begin
      cur  = int'(hist[n-SS-1]);
      prv  = int'(hist[n-SS-2]);
      newc = gdec(cur);
      if (pop(cur ^ prv) > 1) m_err = 1;
      m_delta = (newc - m_cnt) & 255;
      m_cnt   = newc;
    end
    if (inc_valid && inc_ready) xfer_obs++;
    if (inc_valid4 && inc_ready4) xfer_obs4++;
    @(posedge clk);
    #1;
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("delta", 32'(delta), 32'(m_delta));
    chk("backlog", 32'(backlog), 32'(m_bl));
    chk("inc_valid", 32'(inc_valid), 32'(m_bl != 0));
    chk("err", 32'(err), 32'(m_err));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("backlog4", 32'(backlog4), 32'(m_bl4));
    chk("inc_valid4", 32'(inc_valid4), 32'(m_bl4 != 0));
    chk("ovf4", 32'(ovf4), 32'(m_ovf4));
  endtask

  // Assert reset, verify everything clears without a clock edge, release on a falling edge
  task automatic do_reset(input logic [7:0] g);
    rst = 1'b1;
    gray_in = g;
    #1;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_delta", 32'(delta), 0);
    chk("rst_backlog", 32'(backlog), 0);
    chk("rst_inc_valid", 32'(inc_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_backlog4", 32'(backlog4), 0);
    chk("rst_ovf4", 32'(ovf4), 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dsum, cur, r;

    rst = 1'b1; gray_in = 8'h00; inc_ready = 1'b0; inc_ready4 = 1'b0;
    xfer_obs = 0; xfer_obs4 = 0;
    model_clear();

    // Start value held through reset is loaded, never counted
    inc_ready = 1'b1; inc_ready4 = 1'b1;
    do_reset(8'h05);
    tick(); tick();
    chk("lat_before_prime", 32'(cnt), 0);
    tick();
    chk("start_cnt", 32'(cnt), 6);
    chk("start_delta", 32'(delta), 0);
    chk("start_backlog", 32'(backlog), 0);
    chk("start_inc_valid", 32'(inc_valid), 0);
    chk("start_err", 32'(err), 0);
    repeat (4) tick();
    chk("start_no_incr", 32'(backlog), 0);

    // Step table starting from 0x80 (count 255)
    vt[0] = '{8'h80, 1'b1, 255, 0, 0, 1'b0, 0};
    vt[1] = '{8'h00, 1'b1,   0, 1, 0, 1'b0, 1};
    vt[2] = '{8'h01, 1'b1,   1, 1, 0, 1'b0, 1};
    vt[3] = '{8'h03, 1'b1,   2, 1, 0, 1'b0, 1};
    vt[4] = '{8'h02, 1'b1,   3, 1, 0, 1'b0, 1};
    vt[5] = '{8'h06, 1'b0,   4, 1, 1, 1'b0, 0};
    vt[6] = '{8'h07, 1'b0,   5, 1, 2, 1'b0, 0};
    vt[7] = '{8'h05, 1'b1,   6, 1, 0, 1'b0, 3};
    vt[8] = '{8'h04, 1'b1,   7, 1, 0, 1'b0, 1};
    vt[9] = '{8'h0C, 1'b1,   8, 1, 0, 1'b0, 1};
    do_reset(8'h80);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      gray_in = vt[i].g; inc_ready = vt[i].rdy; inc_ready4 = vt[i].rdy;
      xfer_obs = 0; dsum = 0;
      repeat (6) begin
        tick();
        dsum = (dsum + int'(delta)) & 255;
      end
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_dsum", i), 32'(dsum), 32'(vt[i].dsum));
      chk($sformatf("vec%0d_backlog", i), 32'(backlog), 32'(vt[i].bl));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].er));
      chk($sformatf("vec%0d_xfers", i), 32'(xfer_obs), 32'(vt[i].xf));
    end

    // Two gray bits flipping at once: flagged, still decoded and counted
    inc_ready = 1'b0; inc_ready4 = 1'b0;
    do_reset(8'h00);
    repeat (3) tick();
    gray_in = 8'h03;
    repeat (6) tick();
    chk("jump_err", 32'(err), 1);
    chk("jump_cnt", 32'(cnt), 2);
    chk("jump_backlog", 32'(backlog), 2);
    repeat (4) tick();
    chk("jump_err_sticky", 32'(err), 1);

    // Narrow backlog saturates and flags overflow, then drains exactly its capacity
    do_reset(8'h00);
    repeat (3) tick();
    for (int i = 1; i <= 20; i++) begin
      gray_in = genc(i);
      tick();
    end
    repeat (4) tick();
    chk("sat_backlog4", 32'(backlog4), 15);
    chk("sat_ovf4", 32'(ovf4), 1);
    chk("sat_wide_backlog", 32'(backlog), 20);
    chk("sat_wide_ovf", 32'(ovf), 0);
    inc_ready4 = 1'b1; xfer_obs4 = 0;
    repeat (25) tick();
    chk("drain_xfers4", 32'(xfer_obs4), 15);
    chk("drain_backlog4", 32'(backlog4), 0);
    chk("drain_ovf4_sticky", 32'(ovf4), 1);

    // Reset mid-run discards backlog; restart produces no transfers
    inc_ready = 1'b0; inc_ready4 = 1'b0;
    do_reset(8'h00);
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) begin
      gray_in = genc(i);
      tick();
    end
    repeat (4) tick();
    chk("pre_rst_backlog", 32'(backlog), 5);
    chk("pre_rst_inc_valid", 32'(inc_valid), 1);
    inc_ready = 1'b1; inc_ready4 = 1'b1;
    do_reset(genc(5));
    xfer_obs = 0;
    repeat (8) tick();
    chk("restart_xfers", 32'(xfer_obs), 0);
    chk("restart_cnt", 32'(cnt), 5);
    chk("restart_backlog", 32'(backlog), 0);

    // Random legal walk, then random walk with occasional jumps
    for (int pass = 0; pass < 2; pass++) begin
      cur = int'($urandom_range(0, 255));
      do_reset(genc(cur));
      repeat (3) tick();
      for (int k = 0; k < 1200; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 60) cur = (cur + 1) & 255;
        else if (pass == 1 && r < 66) cur = int'($urandom_range(0, 255));
        gray_in    = genc(cur);
        inc_ready  = ($urandom_range(0, 99) < 75);
        inc_ready4 = ($urandom_range(0, 99) < 60);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
